// File: rtl/pixel_quad_packer_if.sv
// Pixel stream in / packed-word stream out bundle for pixel_quad_packer.
// master = the video source / dither side, slave = the packer itself.
interface pixel_quad_packer_if;
    logic        pix_vsync;
    logic        pix_de;
    logic [7:0]  pix_data;
    logic [15:0] vout;
    logic        vout_valid;
    logic [2:0]  x_pos;
    logic [2:0]  y_pos;

    modport master (
        output pix_vsync, pix_de, pix_data,
        input  vout, vout_valid, x_pos, y_pos
    );

    modport slave (
        input  pix_vsync, pix_de, pix_data,
        output vout, vout_valid, x_pos, y_pos
    );
endinterface

// File: rtl/pixel_quad_packer.sv
// Packs 8-bit greyscale pixels into 16-bit words of four 4-bit pixels with dither coordinates.
// Build option: PIXEL_ROUNDING_EN selects rounded (saturating) conversion instead of truncation.
module pixel_quad_packer #(
    parameter COLORMODE = "DES"
) (
    input  logic              clk,
    input  logic              rst,
    pixel_quad_packer_if.slave bus
);

    localparam bit MONO = (COLORMODE == "MONO");

    logic [1:0]  cnt_q, cnt_d;
    logic [11:0] nib_q, nib_d;
    logic        de_q, de_d;
    logic [2:0]  word_q, word_d;
    logic [2:0]  line_q, line_d;
    logic [15:0] vout_q, vout_d;
    logic        valid_q, valid_d;
    logic [2:0]  x_q, x_d;
    logic [2:0]  y_q, y_d;

    logic [3:0]  q;
    logic [2:0]  word_inc, line_inc;

`ifdef PIXEL_ROUNDING_EN
    logic [8:0] sum9;
    assign sum9 = {1'b0, bus.pix_data} + 9'd8;
    assign q    = sum9[8] ? 4'hF : sum9[7:4];
`else
    assign q = bus.pix_data[7:4];
`endif

    assign word_inc = (!MONO && word_q == 3'd2) ? 3'd0 : word_q + 3'd1;
    assign line_inc = (!MONO && line_q == 3'd5) ? 3'd0 : line_q + 3'd1;

    // Slot 0 preloads white into the later slots, so a flush can emit nib_q as-is.
    always_comb begin
        cnt_d   = cnt_q;
        nib_d   = nib_q;
        de_d    = de_q;
        word_d  = word_q;
        line_d  = line_q;
        vout_d  = vout_q;
        valid_d = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        if (bus.pix_vsync) begin
            cnt_d  = 2'd0;
            word_d = 3'd0;
            line_d = 3'd0;
            de_d   = 1'b0;
        end else begin
            de_d = bus.pix_de;
            if (bus.pix_de) begin
                cnt_d = cnt_q + 2'd1;
                case (cnt_q)
                    2'd0: nib_d = {q, 8'hFF};
                    2'd1: nib_d[7:4] = q;
                    2'd2: nib_d[3:0] = q;
                    default: begin
                        vout_d  = {nib_q, q};
                        valid_d = 1'b1;
                        x_d     = word_q;
                        y_d     = line_q;
                        word_d  = word_inc;
                    end
                endcase
            end else if (de_q) begin
                if (cnt_q != 2'd0) begin
                    vout_d  = {nib_q, 4'hF};
                    valid_d = 1'b1;
                    x_d     = word_q;
                    y_d     = line_q;
                end
                cnt_d  = 2'd0;
                word_d = 3'd0;
                line_d = line_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 2'd0;
            nib_q   <= 12'h000;
            de_q    <= 1'b0;
            word_q  <= 3'd0;
            line_q  <= 3'd0;
            vout_q  <= 16'h0000;
            valid_q <= 1'b0;
            x_q     <= 3'd0;
            y_q     <= 3'd0;
        end else begin
            cnt_q   <= cnt_d;
            nib_q   <= nib_d;
            de_q    <= de_d;
            word_q  <= word_d;
            line_q  <= line_d;
            vout_q  <= vout_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign bus.vout       = vout_q;
    assign bus.vout_valid = valid_q;
    assign bus.x_pos      = x_q;
    assign bus.y_pos      = y_q;

endmodule
